// File: rtl/mem_conv_pkg.sv
// Shared widths, GPIO bit map and readback state encoding for the 2D-convolution test path.
package mem_conv_pkg;

    localparam int BIT_LEN    = 8;
    localparam int RAM_WIDTH  = 13;
    localparam int NB_ADDRESS = 10;
    localparam int GPIO_D     = 32;

    localparam int REQ_BIT   = 5;
    localparam int START_BIT = 6;
    localparam int ACK_BIT   = 13;
    localparam int DONE_BIT  = 14;
    localparam int BUSY_BIT  = 15;
    localparam int ERR_BIT   = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REQ = 2'd1,
        FETCH    = 2'd2,
        CAPTURE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/gpio_evt_det.sv
// Registered-previous edge detector for one GPIO command bit: toggle event or rising event.
// prev_q has no reset so that the level present during reset never looks like a fresh event.
module gpio_evt_det #(
    parameter bit TOGGLE = 1'b1
) (
    input  logic CLK100MHZ,
    input  logic sig_i,
    output logic evt_o
);

    logic prev_q;

    always_ff @(posedge CLK100MHZ) begin
        prev_q <= sig_i;
    end

    assign evt_o = TOGGLE ? (sig_i ^ prev_q) : (sig_i & ~prev_q);

endmodule

// File: rtl/gpio_result_reader.sv
// Result BRAM readback over the GPIO pair: one sample per req toggle, answered by an ack toggle.
// Optional sticky error flag on o_gpio_i[16] when built with `define GPIO_READER_ERR_EN.
//
// state    | meaning
// IDLE     | not serving; waits for start (also the post-done resting state)
// WAIT_REQ | busy, addr points at the next sample, waits for a req toggle
// FETCH    | wcnt down-counter covers the BRAM read latency, addr held
// CAPTURE  | latch sample, flip ack, advance addr or finish
module gpio_result_reader
    import mem_conv_pkg::*;
#(
    parameter int GPIO_D      = mem_conv_pkg::GPIO_D,
    parameter int NB_ADDRESS  = mem_conv_pkg::NB_ADDRESS,
    parameter int RAM_WIDTH   = mem_conv_pkg::RAM_WIDTH,
    parameter int LAST_ADD    = 434,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  CLK100MHZ,
    input  logic                  rst,
    input  logic [GPIO_D-1:0]     i_gpio_o,
    output logic [GPIO_D-1:0]     o_gpio_i,
    output logic [NB_ADDRESS-1:0] o_read_add,
    input  logic [RAM_WIDTH-1:0]  i_mem_data
);

    localparam int WCNT_W = 2;

    rd_state_e             state_q;
    logic [NB_ADDRESS-1:0] addr_q;
    logic [RAM_WIDTH-1:0]  data_q;
    logic [WCNT_W-1:0]     wcnt_q;
    logic                  ack_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  err_s;

    logic req_evt;
    logic start_evt;
    logic unused_gpio;

    assign unused_gpio = ^{i_gpio_o[GPIO_D-1:START_BIT+1], i_gpio_o[REQ_BIT-1:0]};

    gpio_evt_det #(.TOGGLE(1'b1)) u_req_det (
        .CLK100MHZ (CLK100MHZ),
        .sig_i     (i_gpio_o[REQ_BIT]),
        .evt_o     (req_evt)
    );

    gpio_evt_det #(.TOGGLE(1'b0)) u_start_det (
        .CLK100MHZ (CLK100MHZ),
        .sig_i     (i_gpio_o[START_BIT]),
        .evt_o     (start_evt)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            wcnt_q  <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_evt) begin
                        addr_q  <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= WAIT_REQ;
                    end
                end
                WAIT_REQ: begin
                    if (req_evt) begin
                        wcnt_q  <= WCNT_W'(RAM_LATENCY - 1);
                        state_q <= FETCH;
                    end else if (start_evt) begin
                        addr_q <= '0;
                    end
                end
                FETCH: begin
                    if (wcnt_q == '0) begin
                        state_q <= CAPTURE;
                    end else begin
                        wcnt_q <= wcnt_q - WCNT_W'(1);
                    end
                end
                CAPTURE: begin
                    data_q <= i_mem_data;
                    ack_q  <= ~ack_q;
                    // Final sample: addr stays on LAST_ADD, never wraps.
                    if (addr_q == NB_ADDRESS'(LAST_ADD)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        addr_q  <= addr_q + NB_ADDRESS'(1);
                        state_q <= WAIT_REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef GPIO_READER_ERR_EN
    logic err_q;

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (start_evt && (state_q == IDLE || state_q == WAIT_REQ)) begin
            err_q <= 1'b0;
        end else if (req_evt && (state_q == FETCH || state_q == CAPTURE ||
                                 (state_q == IDLE && done_q))) begin
            err_q <= 1'b1;
        end
    end

    assign err_s = err_q;
`else
    assign err_s = 1'b0;
`endif

    assign o_read_add = addr_q;

    always_comb begin
        o_gpio_i                  = '0;
        o_gpio_i[RAM_WIDTH-1:0]   = data_q;
        o_gpio_i[ACK_BIT]         = ack_q;
        o_gpio_i[DONE_BIT]        = done_q;
        o_gpio_i[BUSY_BIT]        = busy_q;
        o_gpio_i[ERR_BIT]         = err_s;
    end

endmodule

// File: tb/tb_gpio_result_reader.sv
// Scoreboard bench: a transfer-level model queues expected acks, a negedge monitor checks them.
module tb_gpio_result_reader;

    localparam int LAST = 434;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic        rst, rst3;
    logic [31:0] gin1, gin3;
    logic [31:0] gout1, gout3;
    logic [9:0]  add1, add3;
    logic [12:0] md1, md3;

    logic [12:0] mem [0:LAST];
    logic [12:0] p3  [0:2];

    gpio_result_reader #(.RAM_LATENCY(1)) dut1 (
        .CLK100MHZ (clk),
        .rst       (rst),
        .i_gpio_o  (gin1),
        .o_gpio_i  (gout1),
        .o_read_add(add1),
        .i_mem_data(md1)
    );

    gpio_result_reader #(.RAM_LATENCY(3)) dut3 (
        .CLK100MHZ (clk),
        .rst       (rst3),
        .i_gpio_o  (gin3),
        .o_gpio_i  (gout3),
        .o_read_add(add3),
        .i_mem_data(md3)
    );

    always @(posedge clk) md1 <= mem[add1];
    always @(posedge clk) begin
        p3[0] <= mem[add3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign md3 = p3[2];

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Transfer-level reference model for dut1 (read latency 1)
    typedef struct {
        logic [12:0] data;
        bit          ack;
        bit          done;
        bit          busy;
        int          cyc_at;
    } exp_t;

    exp_t exp_q[$];

    int m_idx = 0;
    int m_cap = -1;
    bit m_ready = 0;
    bit m_done = 0;
    bit m_err = 0;
    bit m_ack = 0;

    function automatic logic exp_err();
`ifdef GPIO_READER_ERR_EN
        return m_err;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_req(input int e);
        exp_t x;
        if (e <= m_cap) begin
            m_err = 1;
        end else if (m_ready) begin
            m_ack    = ~m_ack;
            x.data   = mem[m_idx];
            x.ack    = m_ack;
            x.done   = (m_idx == LAST);
            x.busy   = (m_idx != LAST);
            x.cyc_at = e + 2;
            exp_q.push_back(x);
            m_cap = x.cyc_at;
            if (m_idx == LAST) begin
                m_ready = 0;
                m_done  = 1;
            end else begin
                m_idx++;
            end
        end else if (m_done) begin
            m_err = 1;
        end
    endtask

    task automatic toggle_req();
        @(posedge clk); #1;
        gin1[5] = ~gin1[5];
        model_req(cyc + 1);
    endtask

    task automatic start_pulse();
        @(posedge clk); #1;
        gin1[6] = 1'b1;
        m_idx = 0; m_done = 0; m_err = 0; m_ready = 1;
        @(posedge clk); #1;
        gin1[6] = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        check(nm, exp_q.size(), 0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every ack toggle must match the head of the scoreboard
    logic last_ack = 1'b0;
    always @(negedge clk) begin
        exp_t x;
        if (gout1[13] !== last_ack) begin
            last_ack = gout1[13];
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_ack: got ack %0b with nothing pending (cycle %0d)", gout1[13], cyc);
            end else begin
                x = exp_q.pop_front();
                check("ack_val",   {31'b0, gout1[13]}, {31'b0, x.ack});
                check("ack_data",  {19'b0, gout1[12:0]}, {19'b0, x.data});
                check("ack_cycle", cyc, x.cyc_at);
                check("ack_done",  {31'b0, gout1[14]}, {31'b0, x.done});
                check("ack_busy",  {31'b0, gout1[15]}, {31'b0, x.busy});
                check("ack_hi0",   {17'b0, gout1[31:17]}, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen3;
        for (int i = 0; i <= LAST; i++) mem[i] = 13'(i * 3);
        mem[0] = 13'h1F94;
        rst  = 1'b1;
        rst3 = 1'b1;
        gin1 = 32'h0000_0020;
        gin3 = 32'h0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle_cycles(3);
        check("reset_status", gout1, 32'h0);
        check("reset_addr", {22'b0, add1}, 32'h0);

        start_pulse();
        idle_cycles(2);
        check("start_status", gout1, 32'h0000_8000);
        check("start_addr", {22'b0, add1}, 32'h0);

        toggle_req();
        wait_drain("single_drain");
        check("single_addr", {22'b0, add1}, 32'd1);

        toggle_req();
        toggle_req();
        wait_drain("overlap_drain");
        idle_cycles(4);
        check("overlap_addr", {22'b0, add1}, 32'd2);
        check("overlap_err", {31'b0, gout1[16]}, {31'b0, exp_err()});

        mem[0] = 13'h0;
        start_pulse();
        idle_cycles(2);
        check("restart_addr", {22'b0, add1}, 32'h0);
        check("restart_flags", {13'b0, gout1[31:13]}, 32'h4);

        for (int i = 0; i <= LAST; i++) begin
            toggle_req();
            wait_drain("sweep_drain");
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        idle_cycles(2);
        check("sweep_end_addr", {22'b0, add1}, 32'd434);
        check("sweep_end_done", {31'b0, gout1[14]}, 32'd1);
        check("sweep_end_busy", {31'b0, gout1[15]}, 32'd0);

        toggle_req();
        idle_cycles(6);
        check("postdone_data", {19'b0, gout1[12:0]}, 32'd1302);
        check("postdone_addr", {22'b0, add1}, 32'd434);
        check("postdone_err", {31'b0, gout1[16]}, {31'b0, exp_err()});

        start_pulse();
        idle_cycles(2);
        check("clear_done", {31'b0, gout1[14]}, 32'd0);
        check("clear_err", {31'b0, gout1[16]}, 32'd0);
        check("clear_addr", {22'b0, add1}, 32'd0);

        for (int i = 0; i < 40; i++) mem[i] = 13'($urandom);
        for (int i = 0; i < 40; i++) begin
            toggle_req();
            if ($urandom_range(0, 4) == 0) toggle_req();
            wait_drain("rand_drain");
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
        idle_cycles(2);
        check("rand_addr", {22'b0, add1}, 32'd40);
        check("rand_err", {31'b0, gout1[16]}, {31'b0, exp_err()});

        // Latency-3 instance: reset lands while the fetch is still counting
        @(posedge clk); #1 rst3 = 1'b0;
        idle_cycles(2);
        @(posedge clk); #1 gin3[6] = 1'b1;
        @(posedge clk); #1 gin3[6] = 1'b0;
        idle_cycles(2);
        check("l3_start_status", gout3, 32'h0000_8000);
        @(posedge clk); #1 gin3[5] = ~gin3[5];
        @(posedge clk); #1 rst3 = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 rst3 = 1'b0;
        seen3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen3 = seen3 | gout3[13];
        end
        check("l3_no_ack", {31'b0, seen3}, 32'd0);
        check("l3_status", gout3, 32'h0);
        check("l3_addr", {22'b0, add3}, 32'h0);
        @(posedge clk); #1 gin3[5] = ~gin3[5];
        idle_cycles(6);
        check("l3_idle_ignores_req", gout3, 32'h0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gpio_result_reader.md
Name: gpio_result_reader

Overview:
- Readback engine for the 2D-convolution test path. The micro pulls convolution results out of the result BRAM (mem0) one sample per handshake over the 32-bit GPIO pair.
- Owns the result BRAM read port. It reads each entry, registers it, and signals each new sample with a toggle handshake.
- Once the start command arrives, it walks addresses 0..LAST_ADD in order and asserts done after the final sample.

Parameters:
- GPIO_D, 32, GPIO bus width in each direction.
- NB_ADDRESS, 10, BRAM address width.
- RAM_WIDTH, 13, BRAM data width (signed conv result).
- LAST_ADD, 434, last result address to serve (435 samples).
- RAM_LATENCY, 1, BRAM read latency in cycles (valid range 1..3).

Ports:
- CLK100MHZ  in  1  system clock.
- rst  in  1  reset; synchronous, active-high; clock CLK100MHZ.
- i_gpio_o  in  GPIO_D  micro→fabric command word. Bit 5 = req_tgl. Bit 6 = start. Other bits ignored.
- o_gpio_i  out  GPIO_D  fabric→micro status word:
  - [12:0] data.
  - [13] ack_tgl.
  - [14] done.
  - [15] busy.
  - [16] err (only with the optional feature).
  - All other bits 0.
- o_read_add  out  NB_ADDRESS  result BRAM read address.
- i_mem_data  in  RAM_WIDTH  result BRAM read data, valid RAM_LATENCY cycles after the address.

Behaviour:
- Reset: state IDLE; addr=0; data_q=0; ack_tgl=0; done=0; busy=0; err=0; o_read_add=0. During reset, req_prev <= i_gpio_o[5], so the first request after reset is not spurious. start_prev <= i_gpio_o[6].
- Reset mid-transfer aborts immediately; no ack is issued for a pending request.
- o_read_add is always driven from the addr register.
- Edge detection: req_evt = i_gpio_o[5] ^ req_prev; start_evt = i_gpio_o[6] & ~start_prev. Both prev registers update every cycle.
- States:
  - IDLE: busy=0. start_evt → addr=0, done=0, go WAIT_REQ. req_evt ignored.
  - WAIT_REQ: busy=1. req_evt → wcnt=RAM_LATENCY-1, go FETCH. start_evt → addr=0, stay.
  - FETCH: counts wcnt down to 0 while addr is held, then goes CAPTURE.
  - CAPTURE: single cycle.
    - data_q <= i_mem_data; ack_tgl flips.
    - If addr==LAST_ADD: done=1, addr held, go IDLE.
    - Otherwise: addr <= addr+1, go WAIT_REQ.
- Latency: if req_evt is sampled at edge E, data and ack_tgl are updated at edge E+RAM_LATENCY+1. The micro must see ack_tgl change before reading the data bits.
- In FETCH or CAPTURE, req_evt (request overlap) and start_evt are ignored; the transfer completes normally.
- A req_evt in IDLE after done is ignored: no ack, data held.
- data_q holds the last sample until the next CAPTURE. done persists until start_evt or rst.
- addr never exceeds LAST_ADD; there is no wrap-around.
- No arithmetic on data. It is passed raw; bits [31:17] are tied 0.

Optional Feature:
- Macro GPIO_READER_ERR_EN.
- Defined: o_gpio_i[16] = sticky err. err is set by a req_evt in FETCH/CAPTURE, or by a req_evt in IDLE while done=1. err is cleared only by start_evt or rst. err does not alter the data path.
- Undefined: bit 16 is tied 0, and these events are silently ignored.

Decomposition:
- Shared package mem_conv_pkg holds:
  - Width constants: BIT_LEN, RAM_WIDTH, NB_ADDRESS, GPIO_D.
  - GPIO bit positions: REQ_BIT=5, START_BIT=6, ACK_BIT=13, DONE_BIT=14, BUSY_BIT=15, ERR_BIT=16.
  - State encoding localparams: IDLE, WAIT_REQ, FETCH, CAPTURE.
- One natural sub-module: gpio_evt_det, which holds the registered prev bit and produces the toggle and rise events. It is instantiated for req and for start.

Test Plan:
- Reset and start: hold rst 3 cycles with req_tgl=1, then release, then pulse start. Expect o_gpio_i==32'h0000_8000 (busy only), o_read_add=0, and no ack.
- Single read: BRAM[0]=13'h1F94, RAM_LATENCY=1, toggle req. Expect o_gpio_i[12:0]=13'h1F94 and ack_tgl=1 exactly 2 edges later, and o_read_add=1.
- Full sweep: BRAM[i]=i*3, 435 handshakes, with the bench waiting for each ack. Expect data sequence 0,3,…,1302; done=1 and busy=0 after the last ack; o_read_add held at 434.
- Overlap: toggle req twice, 1 cycle apart. Expect one ack, addr advanced by 1, and err=1 with GPIO_READER_ERR_EN (0 without).
- Post-done request: after the sweep, toggle req. Expect no ack change and data held at 1302. Then pulse start: expect done=0, err=0, addr=0.
- Reset mid-fetch with RAM_LATENCY=3: assert rst 1 cycle after req_evt. Expect no ack, all status bits 0, and state IDLE.
